// File: rtl/vga_rst_ctrl_if.sv
// Control bundle between the VGA reset/enable controller and the pixel driver.
// master: the controller (drives resets and strobes, reads the enable request).
// slave:  the driver side.
interface vga_rst_ctrl_if;
   logic       en;
   logic       rst_sync;
   logic       pix_ce;
   logic       run;
   logic [1:0] state;

   modport master (
      input  en,
      output rst_sync,
      output pix_ce,
      output run,
      output state
   );

   modport slave (
      output en,
      input  rst_sync,
      input  pix_ce,
      input  run,
      input  state
   );
endinterface

// File: rtl/vga_rst_ctrl.sv
// VGA reset sequencer: synchronizes reset release and the enable request, holds the
// downstream reset for HOLD_CYCLES after release, then gates a divided pixel
// clock-enable while the driver is enabled.
module vga_rst_ctrl #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned PIX_DIV     = 2
) (
   input  logic           clk,
   input  logic           rst,
   vga_rst_ctrl_if.master bus
);

   localparam logic [1:0] StRst  = 2'd0;
   localparam logic [1:0] StHold = 2'd1;
   localparam logic [1:0] StIdle = 2'd2;
   localparam logic [1:0] StRun  = 2'd3;

   localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned DivW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
   localparam logic [DivW-1:0]  DivMax  = DivW'(PIX_DIV - 1);

   logic             rs_meta;
   logic             rs;
   logic             en_meta;
   logic             en_s;
   logic [1:0]       state_q, state_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic [DivW-1:0]  div_q, div_d;
   logic             rst_sync_q;
   logic             run_q;
   logic             pix_ce_q;

   // Reset-release synchronizer: asserts immediately, releases two edges later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rs_meta <= 1'b1;
         rs      <= 1'b1;
      end else begin
         rs_meta <= 1'b0;
         rs      <= rs_meta;
      end
   end

   // Enable synchronizer; en is asynchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_meta <= 1'b0;
         en_s    <= 1'b0;
      end else begin
         en_meta <= bus.en;
         en_s    <= en_meta;
      end
   end

   // Next-state logic; counters idle at zero outside their own state.
   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      div_d   = '0;
      case (state_q)
         StRst: begin
            if (!rs) state_d = StHold;
         end
         StHold: begin
            if (hold_q == HoldMax) state_d = StIdle;
            else                   hold_d  = hold_q + HoldW'(1);
         end
         StIdle: begin
            if (en_s) state_d = StRun;
         end
         StRun: begin
            if (!en_s)                state_d = StIdle;
            else if (div_q != DivMax) div_d   = div_q + DivW'(1);
         end
         default: state_d = StRst;
      endcase
   end

   // State, counters and registered outputs all derived from next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StRst;
         hold_q     <= '0;
         div_q      <= '0;
         rst_sync_q <= 1'b1;
         run_q      <= 1'b0;
         pix_ce_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         div_q      <= div_d;
         rst_sync_q <= (state_d == StRst) || (state_d == StHold);
         run_q      <= (state_d == StRun);
         pix_ce_q   <= (state_d == StRun) && (div_d == DivMax);
      end
   end

   assign bus.state    = state_q;
   assign bus.rst_sync = rst_sync_q;
   assign bus.run      = run_q;
   assign bus.pix_ce   = pix_ce_q;

endmodule

// File: tb/tb_vga_rst_ctrl.sv
// Directed bench for vga_rst_ctrl (HOLD_CYCLES=16, PIX_DIV=2, 20 ns clock).
module tb_vga_rst_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   vga_rst_ctrl_if bus ();

   vga_rst_ctrl #(
      .HOLD_CYCLES(16),
      .PIX_DIV    (2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic rs,
                            input logic rn, input logic pc);
      check({tag, " state"},    32'(bus.state),    32'(st));
      check({tag, " rst_sync"}, 32'(bus.rst_sync), 32'(rs));
      check({tag, " run"},      32'(bus.run),      32'(rn));
      check({tag, " pix_ce"},   32'(bus.pix_ce),   32'(pc));
   endtask

   // Expected view of a release sequence, e = edges since rst fell, en_on = en held high.
   task automatic check_release(input int e, input logic en_on);
      logic [1:0] st;
      logic       rn;
      logic       pc;
      if (e <= 2)                st = 2'd0;
      else if (e <= 18)          st = 2'd1;
      else if (en_on && e >= 20) st = 2'd3;
      else                       st = 2'd2;
      rn = (st == 2'd3);
      pc = rn && (((e - 20) % 2) == 1);
      check_all($sformatf("rel%0d e%0d", en_on, e), st, (e < 19), rn, pc);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      bus.en   = 1'b0;

      // Power-on reset, outputs forced before any edge and on every edge.
      #1;
      check_all("por t0", 2'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_all($sformatf("por c%0d", i), 2'd0, 1'b1, 1'b0, 1'b0);
      end

      // Release between edges with en low: HOLD from edge 3, IDLE at edge 19.
      rst = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         tick();
         check_release(e, 1'b0);
      end

      // Raise en after edge k: RUN at k+3, pix_ce 0,1,0,1...
      bus.en = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         if (j < 3) check_all($sformatf("en_up j%0d", j), 2'd2, 1'b0, 1'b0, 1'b0);
         else       check_all($sformatf("en_up j%0d", j), 2'd3, 1'b0, 1'b1,
                              logic'(((j - 3) % 2) == 1));
      end

      // Drop en after edge m = k+8: RUN index continues 6,7 then IDLE at m+3.
      bus.en = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         tick();
         if (j == 1)      check_all("en_dn j1", 2'd3, 1'b0, 1'b1, 1'b0);
         else if (j == 2) check_all("en_dn j2", 2'd3, 1'b0, 1'b1, 1'b1);
         else             check_all($sformatf("en_dn j%0d", j), 2'd2, 1'b0, 1'b0, 1'b0);
      end

      // Re-raise en: divider phase restarts, first pix_ce in second RUN cycle.
      bus.en = 1'b1;
      for (int j = 1; j <= 5; j++) begin
         tick();
         if (j < 3) check_all($sformatf("re_up j%0d", j), 2'd2, 1'b0, 1'b0, 1'b0);
         else       check_all($sformatf("re_up j%0d", j), 2'd3, 1'b0, 1'b1,
                              logic'(((j - 3) % 2) == 1));
      end

      // Half-cycle rst pulse mid-RUN: outputs must clear before the next edge.
      #5;
      rst = 1'b1;
      #1;
      check_all("pulse async", 2'd0, 1'b1, 1'b0, 1'b0);
      #3;
      rst = 1'b0;

      // Release with en held high: HOLD at 3, IDLE at 19, RUN at 20.
      for (int e = 1; e <= 22; e++) begin
         tick();
         check_release(e, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_rst_ctrl.md
VGA_RST_CTRL -- requirements
Module: vga_rst_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, default 16, number of clk cycles rst_sync stays asserted after synchronized reset release; legal range >= 1.
REQ-002 Parameter: PIX_DIV, default 2, clk cycles per pix_ce pulse; legal range >= 1.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  driver enable request, asynchronous to clk, level-sensitive.
REQ-006 Port: rst_sync  output  1  downstream reset, active-high; asserts asynchronously, deasserts synchronously to clk.
REQ-007 Port: pix_ce  output  1  pixel clock-enable, single-cycle pulses while running.
REQ-008 Port: run  output  1  high while the state machine is in RUN.
REQ-009 Port: state  output  2  current state: RST=0, HOLD=1, IDLE=2, RUN=3.

Function
REQ-010 rst release SHALL pass through a 2-flop synchronizer (both flops forced to 1 by rst); the internal synchronized reset rs is the second flop.
REQ-011 en SHALL pass through a 2-flop synchronizer (reset to 0) producing en_s; only en_s is used by the state machine.
REQ-012 State RST SHALL be held while rs=1; on the first edge with rs=0 the state SHALL move to HOLD, i.e. edge 3 after rst falls between edges.
REQ-013 In HOLD, a hold counter (width $clog2(HOLD_CYCLES+1)) SHALL start at 0, increment each edge, and the state SHALL move to IDLE on the edge where the counter equals HOLD_CYCLES-1; HOLD lasts exactly HOLD_CYCLES cycles.
REQ-014 rst_sync SHALL be a registered output: 1 in RST and HOLD, 0 in IDLE and RUN; it falls on the same edge that enters IDLE.
REQ-015 en_s changes in RST or HOLD SHALL be ignored; IDLE SHALL move to RUN on any edge where en_s=1, including the first edge after entering IDLE.
REQ-016 RUN SHALL move to IDLE on any edge where en_s=0; no other exit from RUN exists except rst.
REQ-017 A divider counter (width $clog2(PIX_DIV), min 1) SHALL be 0 on entry to RUN, increment each RUN cycle, and wrap from PIX_DIV-1 to 0.
REQ-018 pix_ce SHALL be 1 exactly during RUN cycles where the divider equals PIX_DIV-1; PIX_DIV=1 gives pix_ce constantly 1 in RUN.
REQ-019 pix_ce SHALL be 0 in RST, HOLD, and IDLE; leaving RUN SHALL clear the divider so re-entry restarts the phase at 0.
REQ-020 run SHALL be registered, 1 exactly in cycles where state=RUN.
REQ-021 Hold and divider counters SHALL never exceed HOLD_CYCLES-1 and PIX_DIV-1; no overflow path exists.

Reset
REQ-022 While rst=1, all outputs SHALL be forced asynchronously: rst_sync=1, pix_ce=0, run=0, state=0; all counters and synchronizer flops SHALL hold their reset values.
REQ-023 rst asserted in any state, including mid-HOLD or mid-RUN, SHALL take effect without waiting for a clk edge and SHALL restart the full REQ-012..REQ-014 sequence after release.

Verification (clk 20 ns, HOLD_CYCLES=16, PIX_DIV=2)
REQ-024 Power-on with rst=1 for 5 cycles, en=0 -> rst_sync=1, run=0, pix_ce=0, and state=0 in every cycle.
REQ-025 rst falls between edges, en=0 -> state=0 through edge 2, state=1 from edge 3, state=2 and rst_sync=0 at edge 19, then state stays 2.
REQ-026 From IDLE, raise en at edge k -> run=1 at edge k+3; pix_ce pattern from RUN entry is 0,1,0,1,...
REQ-027 Drop en in RUN at edge m -> state=2 and run=0 at edge m+3 with pix_ce=0 from that cycle; re-raise en -> the first pix_ce falls in the second RUN cycle again.
REQ-028 rst pulsed mid-RUN (half-cycle) -> rst_sync=1, run=0, pix_ce=0, state=0 immediately, before the next edge; after release with en=1 held -> state=1 at edge 3, IDLE at edge 19, RUN at edge 20.
REQ-029 en=1 held across rst release -> no RUN entry before edge 20; rst_sync=1 for all cycles before edge 19.
